// File: rtl/riscv_pkg.sv
// Shared front-end types and constants: fetch FSM states, base opcodes and
// the default reset PC used by the instruction fetch unit.
package riscv_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of {instr, pc} with flush. When empty the head
// outputs hold the last entry that was presented.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            push,
   input  logic [31:0]     pushInstr,
   input  logic [XLEN-1:0] pushPc,
   input  logic            pop,
   output logic            valid,
   output logic            full,
   output logic [31:0]     headInstr,
   output logic [XLEN-1:0] headPc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]     memInstr [DEPTH];
   logic [XLEN-1:0] memPc    [DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [CNT_W-1:0] count;
   logic [31:0]     holdInstr;
   logic [XLEN-1:0] holdPc;
   logic            doPush, doPop;

   assign valid  = (count != '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign doPush = push && !full;
   assign doPop  = pop && valid;

   assign headInstr = valid ? memInstr[rdPtr] : holdInstr;
   assign headPc    = valid ? memPc[rdPtr]    : holdPc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         count     <= '0;
         holdInstr <= '0;
         holdPc    <= '0;
      end else begin
         // Shadow the head so the outputs keep their value once drained
         if (valid) begin
            holdInstr <= memInstr[rdPtr];
            holdPc    <= memPc[rdPtr];
         end
         if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
         end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !flush && doPush) begin
         memInstr[wrPtr] <= pushInstr;
         memPc[wrPtr]    <= pushPc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words one at a time and feeds
// decode through a small buffer. Optional macro: FETCH_MISALIGN_CHECK_EN.
//   state | meaning
//   REQ   | may issue a fetch at fetchPc when the buffer has room
//   WAIT  | one request outstanding, response will be buffered
//   DRAIN | one request outstanding after a redirect, response is dropped
//   HALT  | misaligned redirect seen, no further fetches until reset
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      op
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic            misalign
`endif
);

   fetch_state_e    state, nextState;
   logic [XLEN-1:0] fetchPc, nextPc, redirPc;
   logic            reqValid, accepted, push, pop, flush;
   logic            bufValid, bufFull;

   assign redirPc = redirect_pc & ~XLEN'(3);

   always_comb begin
      nextState = state;
      nextPc    = fetchPc;
      reqValid  = 1'b0;
      push      = 1'b0;
      flush     = 1'b0;
      accepted  = 1'b0;
      case (state)
         REQ: begin
            reqValid = !bufFull;
            accepted = reqValid && imem_req_ready;
            if (accepted) begin
               nextPc    = fetchPc + XLEN'(4);
               nextState = WAIT;
            end
         end
         WAIT: begin
            push = imem_rsp_valid;
            if (imem_rsp_valid) nextState = REQ;
         end
         DRAIN: begin
            if (imem_rsp_valid) nextState = REQ;
         end
         default: ;
      endcase
      // A request still in flight after the redirect must be drained, even if
      // we were already draining an older one.
      if (redirect_valid) begin
         flush  = 1'b1;
         push   = 1'b0;
         nextPc = redirPc;
         if (accepted || ((state inside {WAIT, DRAIN}) && !imem_rsp_valid))
            nextState = DRAIN;
         else
            nextState = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
         if ((state == HALT) || (redirect_pc[1:0] != 2'b00))
            nextState = HALT;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= REQ;
         fetchPc <= RESET_PC;
      end else begin
         state   <= nextState;
         fetchPc <= nextPc;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst)
         misalign <= 1'b0;
      else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
         misalign <= 1'b1;
   end
`endif

   assign imem_req_valid = reqValid && rst;
   assign imem_req_addr  = fetchPc;
   assign pop            = bufValid && instr_ready;
   assign instr_valid    = bufValid;
   assign op             = instr[6:0];

   fetch_buffer #(
      .XLEN  (XLEN),
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .pushInstr (imem_rsp_data),
      .pushPc    (fetchPc - XLEN'(4)),
      .pop       (pop),
      .valid     (bufValid),
      .full      (bufFull),
      .headInstr (instr),
      .headPc    (instr_pc)
   );

endmodule
